// File: rtl/spu_boot_loader.sv
// Boot loader that unpacks a header-framed word stream into SPU instruction,
// register-file and local-store preload writes, then raises done.
module spu_boot_loader (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [0:31]   in_data,
  output logic          in_ready,
  output logic          load_en,
  output logic [0:31]   instruction_in,
  output logic [0:9]    instr_load_addr,
  output logic          preload_en,
  output logic [0:9]    preload_addr,
  output logic [0:127]  preload_values,
  output logic          preload_LS_en,
  output logic [0:14]   preload_LS_addr,
  output logic [0:127]  preload_LS_data,
  output logic          done
);

  typedef enum logic [1:0] {HDR, COLLECT, WRITE, DONE} state_t;

  localparam logic [1:0] TYPE_INSTR = 2'b00;
  localparam logic [1:0] TYPE_REG   = 2'b01;
  localparam logic [1:0] TYPE_LS    = 2'b10;
  localparam logic [1:0] TYPE_END   = 2'b11;

  state_t      state, next_state;
  logic [1:0]  rec_type;
  logic [0:14] cur_addr;
  logic [0:14] remaining;
  logic [1:0]  word_cnt;
  logic [0:95] assembly;

  logic [1:0]  hdr_type;
  logic [0:14] hdr_addr;
  logic [0:14] hdr_count;
  logic        xfer;
  logic        last_word;

  assign hdr_type  = in_data[0:1];
  assign hdr_addr  = in_data[2:16];
  assign hdr_count = in_data[17:31];
  assign xfer      = in_valid && in_ready;
  assign last_word = (rec_type == TYPE_INSTR) || (word_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= HDR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      HDR: begin
        if (xfer) begin
          if (hdr_type == TYPE_END) begin
            next_state = DONE;
          end else if (hdr_count != '0) begin
            next_state = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (xfer && last_word) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        next_state = (remaining == 15'd1) ? HDR : COLLECT;
      end
      DONE: begin
        next_state = DONE;
      end
      default: begin
        next_state = HDR;
      end
    endcase
  end

  // Everything is gated by rst so nothing is offered or strobed during reset cycles.
  always_comb begin
    in_ready      = 1'b0;
    load_en       = 1'b0;
    preload_en    = 1'b0;
    preload_LS_en = 1'b0;
    done          = 1'b0;
    if (rst) begin
      case (state)
        HDR, COLLECT: in_ready = 1'b1;
        WRITE: begin
          case (rec_type)
            TYPE_INSTR: load_en       = 1'b1;
            TYPE_REG:   preload_en    = 1'b1;
            TYPE_LS:    preload_LS_en = 1'b1;
            default:    ;
          endcase
        end
        DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

  // The final word of an item goes straight into the output register so the
  // strobe in WRITE sees the complete item without an extra assembly cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rec_type        <= TYPE_INSTR;
      cur_addr        <= '0;
      remaining       <= '0;
      word_cnt        <= '0;
      assembly        <= '0;
      instruction_in  <= '0;
      instr_load_addr <= '0;
      preload_addr    <= '0;
      preload_values  <= '0;
      preload_LS_addr <= '0;
      preload_LS_data <= '0;
    end else begin
      case (state)
        HDR: begin
          if (xfer && hdr_type != TYPE_END && hdr_count != '0) begin
            rec_type  <= hdr_type;
            cur_addr  <= hdr_addr;
            remaining <= hdr_count;
            word_cnt  <= '0;
          end
        end
        COLLECT: begin
          if (xfer) begin
            word_cnt <= word_cnt + 2'd1;
            case (word_cnt)
              2'd0:    assembly[0:31]  <= in_data;
              2'd1:    assembly[32:63] <= in_data;
              2'd2:    assembly[64:95] <= in_data;
              default: ;
            endcase
            if (last_word) begin
              case (rec_type)
                TYPE_INSTR: begin
                  instruction_in  <= in_data;
                  instr_load_addr <= cur_addr[5:14];
                end
                TYPE_REG: begin
                  preload_values <= {assembly, in_data};
                  preload_addr   <= cur_addr[5:14];
                end
                TYPE_LS: begin
                  preload_LS_data <= {assembly, in_data};
                  preload_LS_addr <= cur_addr;
                end
                default: ;
              endcase
            end
          end
        end
        WRITE: begin
          cur_addr  <= cur_addr + 15'd1;
          remaining <= remaining - 15'd1;
          word_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
